// File: rtl/iiitb_rtc_alarm.sv
// -----------------------------------------------------------------------------
// iiitb_rtc_alarm
//   Alarm unit that sits behind the RTC digit counters. It holds an editable
//   alarm time (BCD hh:mm), compares it against the running time once per
//   hundred_clk cycle (one RTC second per cycle), and runs an IDLE/RING/SNOOZE
//   state machine that drives a gated buzzer and status flags.
//
// Parameters
//   RING_LEN   : cycles the alarm rings before timing out (2..4095)
//   BUZZ_HALF  : buzzer half-period in cycles (1..15)
//   SNOOZE_MIN : snooze delay in minutes (1..9)
//   MAX_SNOOZE : snoozes allowed per alarm event (0..7)
//
// Ports
//   hundred_clk           : clock, all state changes on rising edge
//   rst                   : synchronous active-low reset
//   hrm,hrl,minm,minl,
//   secm,secl             : current BCD time from the RTC
//   alarm_on              : level, alarm armed
//   set_mode              : level, alarm-time edit mode
//   hr_inc, min_inc       : edit buttons (rising-edge detected)
//   snooze, stop          : user buttons (rising-edge detected)
//   al_hrm..al_minl       : stored alarm time, BCD
//   ringing               : high while ringing
//   buzz                  : square wave while ringing, else 0
//   snoozed               : high while snoozed
//   missed                : sticky, set on ring timeout
// -----------------------------------------------------------------------------
module iiitb_rtc_alarm #(
  parameter int unsigned RING_LEN   = 60,
  parameter int unsigned BUZZ_HALF  = 2,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic       hundred_clk,
  input  logic       rst,
  input  logic [3:0] hrm,
  input  logic [3:0] hrl,
  input  logic [3:0] minm,
  input  logic [3:0] minl,
  input  logic [3:0] secm,
  input  logic [3:0] secl,
  input  logic       alarm_on,
  input  logic       set_mode,
  input  logic       hr_inc,
  input  logic       min_inc,
  input  logic       snooze,
  input  logic       stop,
  output logic [3:0] al_hrm,
  output logic [3:0] al_hrl,
  output logic [3:0] al_minm,
  output logic [3:0] al_minl,
  output logic       ringing,
  output logic       buzz,
  output logic       snoozed,
  output logic       missed
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RING   = 2'd1,
    S_SNOOZE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // BCD helpers
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] bcd_hr_inc(input logic [7:0] h);
    logic [7:0] r;
    if (h == 8'h23)             r = 8'h00;
    else if (h[3:0] == 4'd9)    r = {h[7:4] + 4'd1, 4'd0};
    else                        r = {h[7:4], h[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_min_inc(input logic [7:0] m);
    logic [7:0] r;
    if (m == 8'h59)             r = 8'h00;
    else if (m[3:0] == 4'd9)    r = {m[7:4] + 4'd1, 4'd0};
    else                        r = {m[7:4], m[3:0] + 4'd1};
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [7:0]  al_hr_q, al_hr_d;
  logic [7:0]  al_min_q, al_min_d;
  logic [15:0] tgt_q, tgt_d;
  logic [11:0] ring_cnt_q, ring_cnt_d;
  logic [3:0]  buzz_cnt_q, buzz_cnt_d;
  logic [2:0]  snooze_cnt_q, snooze_cnt_d;
  logic        hr_inc_q, min_inc_q, snooze_q, stop_q;
  logic        ringing_q, ringing_d;
  logic        buzz_q, buzz_d;
  logic        snoozed_q, snoozed_d;
  logic        missed_q, missed_d;

  // ---------------------------------------------------------------------------
  // Button edge events
  // ---------------------------------------------------------------------------
  logic hr_ev, min_ev, snooze_ev, stop_ev;
  assign hr_ev     = hr_inc  & ~hr_inc_q;
  assign min_ev    = min_inc & ~min_inc_q;
  assign snooze_ev = snooze  & ~snooze_q;
  assign stop_ev   = stop    & ~stop_q;

  // ---------------------------------------------------------------------------
  // Time comparisons
  // ---------------------------------------------------------------------------
  logic sec_zero, match, tgt_hit;
  assign sec_zero = (secm == 4'd0) && (secl == 4'd0);
  assign match    = alarm_on && !set_mode && sec_zero &&
                    ({hrm, hrl} == al_hr_q) && ({minm, minl} == al_min_q);
  assign tgt_hit  = sec_zero && ({hrm, hrl, minm, minl} == tgt_q);

  // ---------------------------------------------------------------------------
  // Snooze target: current hh:mm + SNOOZE_MIN, digit-wise BCD add
  // ---------------------------------------------------------------------------
  logic [15:0] snz_tgt;
  logic [4:0]  ml_sum;
  logic [3:0]  t_minl, t_minm;
  logic [7:0]  t_hr;
  logic        c_minl, c_minm;

  always_comb begin
    ml_sum = {1'b0, minl} + 5'(SNOOZE_MIN);
    c_minl = 1'b0;
    c_minm = 1'b0;
    t_minl = ml_sum[3:0];
    t_minm = minm;
    t_hr   = {hrm, hrl};
    if (ml_sum >= 5'd10) begin
      t_minl = 4'(ml_sum - 5'd10);
      c_minl = 1'b1;
    end
    if (c_minl) begin
      if (minm == 4'd5) begin
        t_minm = 4'd0;
        c_minm = 1'b1;
      end else begin
        t_minm = minm + 4'd1;
      end
    end
    if (c_minm) t_hr = bcd_hr_inc({hrm, hrl});
    snz_tgt = {t_hr, t_minm, t_minl};
  end

  // ---------------------------------------------------------------------------
  // Alarm register editing (IDLE + set_mode only)
  // ---------------------------------------------------------------------------
  always_comb begin
    al_hr_d  = al_hr_q;
    al_min_d = al_min_q;
    if (state_q == S_IDLE && set_mode) begin
      if (hr_ev)  al_hr_d  = bcd_hr_inc(al_hr_q);
      if (min_ev) al_min_d = bcd_min_inc(al_min_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  logic enter_ring, timeout;

  always_comb begin
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    buzz_cnt_d   = '0;
    buzz_d       = 1'b0;
    snooze_cnt_d = snooze_cnt_q;
    tgt_d        = tgt_q;
    enter_ring   = 1'b0;
    timeout      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (match) begin
          state_d    = S_RING;
          enter_ring = 1'b1;
        end
      end
      S_RING: begin
        if (!alarm_on || stop_ev) begin
          state_d = S_IDLE;
        end else if (snooze_ev && (snooze_cnt_q < 3'(MAX_SNOOZE))) begin
          state_d      = S_SNOOZE;
          snooze_cnt_d = snooze_cnt_q + 3'd1;
          tgt_d        = snz_tgt;
        end else if (ring_cnt_q == 12'(RING_LEN - 1)) begin
          state_d = S_IDLE;
          timeout = 1'b1;
        end else begin
          ring_cnt_d = ring_cnt_q + 12'd1;
        end
      end
      S_SNOOZE: begin
        if (!alarm_on || stop_ev) begin
          state_d = S_IDLE;
        end else if (tgt_hit) begin
          state_d    = S_RING;
          enter_ring = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Buzzer phase restarts high on every ring entry, then toggles every
    // BUZZ_HALF cycles while the ring continues.
    if (enter_ring) begin
      ring_cnt_d = '0;
      buzz_d     = 1'b1;
      buzz_cnt_d = '0;
    end else if (state_q == S_RING && state_d == S_RING) begin
      if (buzz_cnt_q == 4'(BUZZ_HALF - 1)) begin
        buzz_d     = ~buzz_q;
        buzz_cnt_d = '0;
      end else begin
        buzz_d     = buzz_q;
        buzz_cnt_d = buzz_cnt_q + 4'd1;
      end
    end else begin
      ring_cnt_d = '0;
    end

    if (state_d == S_IDLE) snooze_cnt_d = '0;

    missed_d = missed_q;
    if (timeout)             missed_d = 1'b1;
    if (stop_ev || set_mode) missed_d = 1'b0;

    ringing_d = (state_d == S_RING);
    snoozed_d = (state_d == S_SNOOZE);
  end

  always_ff @(posedge hundred_clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      al_hr_q      <= '0;
      al_min_q     <= '0;
      tgt_q        <= '0;
      ring_cnt_q   <= '0;
      buzz_cnt_q   <= '0;
      snooze_cnt_q <= '0;
      hr_inc_q     <= 1'b0;
      min_inc_q    <= 1'b0;
      snooze_q     <= 1'b0;
      stop_q       <= 1'b0;
      ringing_q    <= 1'b0;
      buzz_q       <= 1'b0;
      snoozed_q    <= 1'b0;
      missed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      al_hr_q      <= al_hr_d;
      al_min_q     <= al_min_d;
      tgt_q        <= tgt_d;
      ring_cnt_q   <= ring_cnt_d;
      buzz_cnt_q   <= buzz_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      hr_inc_q     <= hr_inc;
      min_inc_q    <= min_inc;
      snooze_q     <= snooze;
      stop_q       <= stop;
      ringing_q    <= ringing_d;
      buzz_q       <= buzz_d;
      snoozed_q    <= snoozed_d;
      missed_q     <= missed_d;
    end
  end

  assign al_hrm  = al_hr_q[7:4];
  assign al_hrl  = al_hr_q[3:0];
  assign al_minm = al_min_q[7:4];
  assign al_minl = al_min_q[3:0];
  assign ringing = ringing_q;
  assign buzz    = buzz_q;
  assign snoozed = snoozed_q;
  assign missed  = missed_q;

endmodule

// File: tb/tb_iiitb_rtc_alarm.sv
// -----------------------------------------------------------------------------
// tb_iiitb_rtc_alarm
//   Directed bench for iiitb_rtc_alarm. Stimulus pushes hand-computed expected
//   output vectors {al_hh, al_mm, ringing, buzz, snoozed, missed} into a
//   scoreboard queue tagged with the cycle they apply to; a monitor pops and
//   compares them on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_iiitb_rtc_alarm;

  logic       hundred_clk;
  logic       rst;
  logic [3:0] hrm, hrl, minm, minl, secm, secl;
  logic       alarm_on, set_mode, hr_inc, min_inc, snooze, stop;
  logic [3:0] al_hrm, al_hrl, al_minm, al_minl;
  logic       ringing, buzz, snoozed, missed;

  iiitb_rtc_alarm #(
    .RING_LEN  (60),
    .BUZZ_HALF (2),
    .SNOOZE_MIN(5),
    .MAX_SNOOZE(3)
  ) dut (
    .hundred_clk(hundred_clk),
    .rst        (rst),
    .hrm        (hrm),
    .hrl        (hrl),
    .minm       (minm),
    .minl       (minl),
    .secm       (secm),
    .secl       (secl),
    .alarm_on   (alarm_on),
    .set_mode   (set_mode),
    .hr_inc     (hr_inc),
    .min_inc    (min_inc),
    .snooze     (snooze),
    .stop       (stop),
    .al_hrm     (al_hrm),
    .al_hrl     (al_hrl),
    .al_minm    (al_minm),
    .al_minl    (al_minl),
    .ringing    (ringing),
    .buzz       (buzz),
    .snoozed    (snoozed),
    .missed     (missed)
  );

  initial begin
    hundred_clk = 1'b0;
    forever #5 hundred_clk = ~hundred_clk;
  end

  int cyc = 0;
  always @(posedge hundred_clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic [19:0] mask;
    logic [19:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  localparam logic [19:0] M_ALL = 20'hFFFFF;
  localparam logic [19:0] M_AL  = 20'hFFFF0;
  localparam logic [19:0] M_RSM = 20'h0000B;

  function automatic logic [19:0] pk(input logic [15:0] al, input logic r,
                                     input logic b, input logic s, input logic m);
    return {al, r, b, s, m};
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic [19:0] act;
  assign act = {al_hrm, al_hrl, al_minm, al_minl, ringing, buzz, snoozed, missed};

  exp_t mon_e;
  always @(negedge hundred_clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      n_vec = n_vec + 1;
      if ((act & mon_e.mask) !== (mon_e.val & mon_e.mask)) begin
        n_fail = n_fail + 1;
        $display("FAIL %s @cyc %0d: got %05h want %05h (mask %05h)",
                 mon_e.name, cyc, act & mon_e.mask, mon_e.val & mon_e.mask, mon_e.mask);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge hundred_clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [19:0] m, input logic [19:0] v);
    exp_t e;
    e.cyc  = cyc;
    e.name = n;
    e.mask = m;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    hrm  = h[7:4];
    hrl  = h[3:0];
    minm = m[7:4];
    minl = m[3:0];
    secm = s[7:4];
    secl = s[3:0];
  endtask

  task automatic press_hr(input int n);
    repeat (n) begin
      hr_inc = 1'b1; tick();
      hr_inc = 1'b0; tick();
    end
  endtask

  task automatic press_min(input int n);
    repeat (n) begin
      min_inc = 1'b1; tick();
      min_inc = 1'b0; tick();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b0;
    alarm_on = 1'b0; set_mode = 1'b0;
    hr_inc = 1'b0; min_inc = 1'b0; snooze = 1'b0; stop = 1'b0;
    set_time(8'h12, 8'h34, 8'h56);

    // Reset and alarm editing
    tick(); tick();
    chk("reset_state", M_ALL, pk(16'h0000, 0, 0, 0, 0));
    rst = 1'b1;
    set_mode = 1'b1;
    press_hr(7);
    press_min(30);
    chk("set_0730", M_ALL, pk(16'h0730, 0, 0, 0, 0));
    press_hr(17);
    chk("hr_wrap", M_AL, pk(16'h0030, 0, 0, 0, 0));
    press_min(29);
    chk("min_59", M_AL, pk(16'h0059, 0, 0, 0, 0));
    press_hr(7);
    press_min(1);
    chk("min_wrap_nocarry", M_AL, pk(16'h0700, 0, 0, 0, 0));
    press_min(29);
    min_inc = 1'b1;
    repeat (4) tick();
    min_inc = 1'b0; tick();
    chk("held_min_one_event", M_AL, pk(16'h0730, 0, 0, 0, 0));

    // Trigger and timeout
    set_mode = 1'b0; alarm_on = 1'b1;
    set_time(8'h07, 8'h29, 8'h59); tick();
    chk("pre_match", M_ALL, pk(16'h0730, 0, 0, 0, 0));
    set_time(8'h07, 8'h30, 8'h00); tick();
    chk("ring_buzz", M_ALL, pk(16'h0730, 1, 1, 0, 0));
    set_time(8'h07, 8'h30, 8'h01);
    for (int k = 1; k < 60; k++) begin
      tick();
      chk("ring_buzz", M_ALL, pk(16'h0730, 1, ((k / 2) % 2) == 0, 0, 0));
    end
    tick();
    chk("timeout_missed", M_ALL, pk(16'h0730, 0, 0, 0, 1));
    stop = 1'b1; tick();
    chk("stop_clears_missed", M_ALL, pk(16'h0730, 0, 0, 0, 0));
    stop = 1'b0; tick();

    // Snooze sequence at 23:58
    set_mode = 1'b1;
    press_hr(16);
    press_min(28);
    set_mode = 1'b0;
    chk("set_2358", M_ALL, pk(16'h2358, 0, 0, 0, 0));
    set_time(8'h23, 8'h58, 8'h00); tick();
    chk("ring_2358", M_ALL, pk(16'h2358, 1, 1, 0, 0));
    set_time(8'h23, 8'h58, 8'h10); tick(); tick();
    snooze = 1'b1; tick();
    chk("snooze1", M_ALL, pk(16'h2358, 0, 0, 1, 0));
    snooze = 1'b0;
    set_time(8'h00, 8'h02, 8'h59); tick();
    chk("snooze_wait", M_ALL, pk(16'h2358, 0, 0, 1, 0));
    set_time(8'h00, 8'h03, 8'h00); tick();
    chk("snooze_rering_0003", M_ALL, pk(16'h2358, 1, 1, 0, 0));
    set_time(8'h00, 8'h03, 8'h01); tick();
    snooze = 1'b1; tick();
    chk("snooze2", M_ALL, pk(16'h2358, 0, 0, 1, 0));
    snooze = 1'b0;
    set_time(8'h00, 8'h08, 8'h00); tick();
    chk("snooze_rering_0008", M_ALL, pk(16'h2358, 1, 1, 0, 0));
    set_time(8'h00, 8'h08, 8'h01);
    snooze = 1'b1; tick();
    chk("snooze3", M_ALL, pk(16'h2358, 0, 0, 1, 0));
    snooze = 1'b0;
    set_time(8'h00, 8'h13, 8'h00); tick();
    chk("snooze_rering_0013", M_ALL, pk(16'h2358, 1, 1, 0, 0));
    set_time(8'h00, 8'h13, 8'h01);
    snooze = 1'b1; tick();
    chk("snooze4_ignored", M_RSM, pk(16'h0000, 1, 0, 0, 0));
    snooze = 1'b0; tick();
    chk("still_ringing", M_RSM, pk(16'h0000, 1, 0, 0, 0));
    stop = 1'b1; tick();
    chk("stop_ring", M_ALL, pk(16'h2358, 0, 0, 0, 0));
    stop = 1'b0; tick();

    // Stop beats snooze in the same cycle
    set_time(8'h23, 8'h58, 8'h00); tick();
    chk("ring_again", M_ALL, pk(16'h2358, 1, 1, 0, 0));
    set_time(8'h23, 8'h58, 8'h01);
    stop = 1'b1; snooze = 1'b1; tick();
    chk("stop_beats_snooze", M_ALL, pk(16'h2358, 0, 0, 0, 0));
    stop = 1'b0; snooze = 1'b0; tick();

    // Guards
    set_mode = 1'b1;
    set_time(8'h23, 8'h58, 8'h00); tick();
    chk("set_mode_blocks", M_ALL, pk(16'h2358, 0, 0, 0, 0));
    set_mode = 1'b0;
    set_time(8'h23, 8'h58, 8'h01); tick();
    chk("set_mode_blocks2", M_ALL, pk(16'h2358, 0, 0, 0, 0));
    set_time(8'h23, 8'h58, 8'h00); tick();
    chk("ring_guard", M_ALL, pk(16'h2358, 1, 1, 0, 0));
    set_time(8'h23, 8'h58, 8'h05);
    snooze = 1'b1; tick();
    chk("snooze_guard", M_ALL, pk(16'h2358, 0, 0, 1, 0));
    snooze = 1'b0; alarm_on = 1'b0; tick();
    chk("alarm_off_in_snooze", M_ALL, pk(16'h2358, 0, 0, 0, 0));
    set_time(8'h00, 8'h03, 8'h00); tick();
    chk("target_silent", M_ALL, pk(16'h2358, 0, 0, 0, 0));
    alarm_on = 1'b1; tick();
    chk("target_silent_armed", M_ALL, pk(16'h2358, 0, 0, 0, 0));
    set_time(8'h00, 8'h03, 8'h01); tick();

    // Reset during ring; held snooze across release
    set_time(8'h23, 8'h58, 8'h00); tick();
    chk("ring_prereset", M_ALL, pk(16'h2358, 1, 1, 0, 0));
    set_time(8'h23, 8'h58, 8'h02); tick();
    rst = 1'b0; snooze = 1'b1; tick();
    chk("reset_mid_ring", M_ALL, pk(16'h0000, 0, 0, 0, 0));
    set_time(8'h00, 8'h00, 8'h00);
    rst = 1'b1; tick();
    chk("ring_0000", M_ALL, pk(16'h0000, 1, 1, 0, 0));
    set_time(8'h00, 8'h00, 8'h01); tick();
    chk("held_snooze_no_event", M_ALL, pk(16'h0000, 1, 1, 0, 0));
    tick();
    chk("held_snooze_no_event2", M_ALL, pk(16'h0000, 1, 0, 0, 0));
    snooze = 1'b0; tick();
    stop = 1'b1; tick();
    chk("final_stop", M_ALL, pk(16'h0000, 0, 0, 0, 0));
    stop = 1'b0;

    repeat (3) tick();
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
      $fatal(1, "scoreboard not drained");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
